// File: rtl/bk_add_scheduler.sv
// bk_add_scheduler: two-requester arbiter that shares one 4-bit Brent-Kung slice,
// computing WIDTH-bit a+b+cin LSB-chunk-first with the carry chained through a register.
`default_nettype none

module Brentkung (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;
  logic [4:1] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Up-sweep pairs, then root span, then the single down-sweep fill-in for bit 2.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;

  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g10  | (p10  & cin_i);
  assign c[3] = g20  | (p20  & cin_i);
  assign c[4] = g30  | (p30  & cin_i);

  assign s_o    = p ^ {c[3:1], cin_i};
  assign cout_o = c[4];
endmodule

module bk_add_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int NCH = WIDTH / 4;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             id_q, id_d, last_grant_q, last_grant_d;
  logic [KW-1:0]    k_q, k_d;

  logic             grant_valid, grant_id;
  logic [3:0]       a_chunk, b_chunk, slice_s;
  logic             slice_cout;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE) begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    end
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid &  grant_id;

  always_comb begin
    a_chunk = 4'd0;
    b_chunk = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[4*i +: 4];
        b_chunk = b_q[4*i +: 4];
      end
    end
  end

  Brentkung u_slice (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    k_d          = k_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          a_d          = grant_id ? req1_a   : req0_a;
          b_d          = grant_id ? req1_b   : req0_b;
          carry_d      = grant_id ? req1_cin : req0_cin;
          k_d          = '0;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCH; i++) begin
          if (k_q == KW'(i)) sum_d[4*i +: 4] = slice_s;
        end
        carry_d = slice_cout;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d  = slice_cout;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      k_q          <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      k_q          <= k_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_bk_add_scheduler.sv
// Scoreboard bench for bk_add_scheduler: drivers issue requests, a monitor pops and checks responses.
`default_nettype none

module tb_bk_add_scheduler;
  localparam int WIDTH = 16;
  localparam int NCH   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req0_ready, req0_cin = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0;
  logic             req1_valid = 1'b0, req1_ready, req1_cin = 1'b0;
  logic [WIDTH-1:0] req1_a = '0, req1_b = '0;
  logic             rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, busy;
  logic [WIDTH-1:0] rsp_sum;

  bk_add_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   auto_exp = 1'b0;
  bit   rand_rdy = 1'b0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  exp_t snap;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic id, input logic [WIDTH:0] r);
    exp_t e;
    e.id   = id;
    e.cout = r[WIDTH];
    e.sum  = r[WIDTH-1:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Accept side: latency reference, auto expectations in random phase, ready legality.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        acc_cyc = cyc + 1;
        if (auto_exp) sbq.push_back(mk(1'b0, {1'b0, req0_a} + req0_b + req0_cin));
      end
      if (req1_valid && req1_ready) begin
        acc_cyc = cyc + 1;
        if (auto_exp) sbq.push_back(mk(1'b1, {1'b0, req1_a} + req1_b + req1_cin));
      end
      if (busy && (req0_valid || req1_valid))
        chk("ready_outside_idle", {30'd0, req0_ready, req1_ready}, 32'd0);
      if (req0_ready && req1_ready) begin
        tests++; fails++;
        $display("FAIL dual_grant: got both readies high, expected at most one");
      end
    end
  end

  // Response side.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, NCH);
      if (rsp_valid && prev_v && !prev_r) chk("hold_stable", {rsp_id, rsp_cout, rsp_sum}, snap);
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got id=%0d sum=%0h, expected no response", rsp_id, rsp_sum);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp", {rsp_id, rsp_cout, rsp_sum}, e);
        end
      end
      prev_v = rsp_valid;
      prev_r = rsp_ready;
      snap   = {rsp_id, rsp_cout, rsp_sum};
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        output int waited);
    int n = 0;
    req0_a = a; req0_b = b; req0_cin = c; req0_valid = 1'b1;
    @(negedge clk);
    while (!req0_ready && n < 300) begin @(negedge clk); n++; end
    waited = n;
    if (!req0_ready) begin
      tests++; fails++;
      $display("FAIL req0_timeout: got no ready after %0d cycles, expected a grant", n);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
  endtask

  task automatic issue1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        output int waited);
    int n = 0;
    req1_a = a; req1_b = b; req1_cin = c; req1_valid = 1'b1;
    @(negedge clk);
    while (!req1_ready && n < 300) begin @(negedge clk); n++; end
    waited = n;
    if (!req1_ready) begin
      tests++; fails++;
      $display("FAIL req1_timeout: got no ready after %0d cycles, expected a grant", n);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy || req0_valid || req1_valid) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w, w1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    chk("reset_outs",  {rsp_id, rsp_cout, rsp_sum}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add, accepted in the same cycle.
    sbq.push_back(mk(1'b0, 17'h05555));
    issue0(16'h1234, 16'h4321, 1'b0, w);
    chk("accept_same_cycle", w, 0);
    drain();

    // Full carry ripple and carry-in ripple.
    sbq.push_back(mk(1'b1, 17'h10000));
    issue1(16'hFFFF, 16'h0001, 1'b0, w);
    sbq.push_back(mk(1'b1, 17'h00100));
    issue1(16'h00FF, 16'h0000, 1'b1, w);
    drain();

    // Round-robin after reset: grant order 0,1,0,1.
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1; @(posedge clk); #1;
    sbq.push_back(mk(1'b0, 17'h03333));
    sbq.push_back(mk(1'b1, 17'h10000));
    sbq.push_back(mk(1'b0, 17'h01000));
    sbq.push_back(mk(1'b1, 17'h10001));
    fork
      begin issue0(16'h1111, 16'h2222, 1'b0, w);  issue0(16'h0F0F, 16'h00F1, 1'b0, w);  end
      begin issue1(16'hA5A5, 16'h5A5A, 1'b1, w1); issue1(16'hC000, 16'h4000, 1'b1, w1); end
    join
    drain();

    // Backpressure with a competing request waiting.
    rsp_ready = 1'b0;
    sbq.push_back(mk(1'b0, 17'h00010));
    sbq.push_back(mk(1'b1, 17'h00002));
    issue0(16'h0007, 16'h0009, 1'b0, w);
    fork
      issue1(16'h0001, 16'h0001, 1'b0, w1);
    join_none
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // Reset after chunk 1 discards the operation; then a tie goes to req0.
    issue0(16'h1111, 16'h1111, 1'b0, w);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_busy",  {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(mk(1'b0, 17'h10000));
    sbq.push_back(mk(1'b1, 17'h01011));
    fork
      issue0(16'h8000, 16'h8000, 1'b0, w);
      issue1(16'h0F0F, 16'h0101, 1'b1, w1);
    join
    drain();

    // Random traffic with gaps and random consumer stalls.
    auto_exp = 1'b1;
    rand_rdy = 1'b1;
    fork
      begin
        repeat (1000) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 issue0(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), w);
        end
      end
      begin
        repeat (1000) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 issue1(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), w1);
        end
      end
    join
    rand_rdy = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    drain();
    chk("queue_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
